// File: rtl/t07_esp_pkg.sv
// Shared types for the ESP32 receive link.
//   ESP_WORD_W     : default word width of the link
//   ESP_FIFO_DEPTH : default receive FIFO depth
//   esp_word_t     : one received word at the default width
//   esp_status_t   : packed status view {overflow, frame_err, count} for MMIO
package t07_esp_pkg;

  localparam int unsigned ESP_WORD_W     = 32;
  localparam int unsigned ESP_FIFO_DEPTH = 8;
  localparam int unsigned ESP_COUNT_MAX_W = 7;  // enough for FIFO_DEPTH up to 64

  typedef logic [ESP_WORD_W-1:0] esp_word_t;

  typedef struct packed {
    logic                       overflow;
    logic                       frame_err;
    logic [ESP_COUNT_MAX_W-1:0] count;
  } esp_status_t;

  function automatic esp_status_t esp_status(input logic ovf, input logic ferr,
                                             input logic [ESP_COUNT_MAX_W-1:0] cnt);
    esp_status_t s;
    s.overflow  = ovf;
    s.frame_err = ferr;
    s.count     = cnt;
    return s;
  endfunction

endpackage

// File: rtl/t07_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (accepted when not full, or when full with a pop)
//   pop      : remove head entry (ignored when empty)
//   wdata    : write word
//   rdata    : head entry, zero when empty
//   full     : occupancy == DEPTH
//   empty    : occupancy == 0
//   count    : current occupancy, 0..DEPTH
module t07_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees the head slot this cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/t07_esp_spi_rx.sv
// SPI mode-0 slave receive front end for the ESP32 link.
//   clk, rst   : system clock, asynchronous active-high reset
//   esp_sclk   : SPI clock from ESP32 (asynchronous)
//   esp_cs_n   : SPI chip select, active-low (asynchronous)
//   esp_mosi   : SPI data (asynchronous)
//   rd_en      : pop strobe for the FIFO head
//   clr_err    : clears overflow and frame_err
//   rd_data    : FIFO head word (zero when empty)
//   rd_valid   : FIFO not empty
//   count      : FIFO occupancy
//   overflow   : sticky, a completed word was dropped on a full FIFO
//   frame_err  : sticky, chip select rose with a partial word
// Requires f_clk >= 4 * f_sclk.
module t07_esp_spi_rx
  import t07_esp_pkg::*;
#(
  parameter int unsigned WORD_W      = ESP_WORD_W,
  parameter int unsigned FIFO_DEPTH  = ESP_FIFO_DEPTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          esp_sclk,
  input  logic                          esp_cs_n,
  input  logic                          esp_mosi,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [WORD_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int unsigned BW = $clog2(WORD_W);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   cs_fall;
  logic                   cs_rise;

  logic [WORD_W-1:0]      shreg;
  logic [WORD_W-1:0]      shift_next;
  logic [BW-1:0]          bit_cnt;
  logic                   armed;
  logic                   push_q;
  logic [WORD_W-1:0]      word_q;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   ovf_event;
  logic                   ferr_event;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  always_comb begin
    shift_next = shreg;
    if (MSB_FIRST) shift_next = {shreg[WORD_W-2:0], mosi_s};
    else           shift_next = {mosi_s, shreg[WORD_W-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], esp_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], esp_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], esp_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Capture is gated by 'armed' so a frame already in progress when reset
  // is released is ignored until the next chip-select falling edge.
  // The completed word is held in word_q for one cycle, so the FIFO write
  // lands SYNC_STAGES+2 clocks after the pin edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      armed   <= 1'b0;
      push_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      push_q <= 1'b0;
      if (cs_fall) begin
        bit_cnt <= '0;
        shreg   <= '0;
        armed   <= 1'b1;
      end else if (cs_rise) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (sclk_rise && !cs_s && armed) begin
        if (bit_cnt == BW'(WORD_W - 1)) begin
          push_q  <= 1'b1;
          word_q  <= shift_next;
          shreg   <= '0;
          bit_cnt <= '0;
        end else begin
          shreg   <= shift_next;
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  assign ovf_event  = push_q & fifo_full & ~(rd_en & ~fifo_empty);
  assign ferr_event = cs_rise & (bit_cnt != '0);

  // Set has priority over clr_err so a coincident event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovf_event)    overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (ferr_event)   frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  t07_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (rd_en),
    .wdata (word_q),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign rd_valid = ~fifo_empty;

endmodule

// File: tb/tb_t07_esp_spi_rx.sv
// Self-checking bench for t07_esp_spi_rx: default instance plus two 8-bit
// instances (LSB-first and MSB-first) on their own chip select.
module tb_t07_esp_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        esp_sclk = 1'b0;
  logic        esp_cs_n = 1'b1;
  logic        cs8_n = 1'b1;
  logic        esp_mosi = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic        rd_en8 = 1'b0;
  logic        clr_err8 = 1'b0;

  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  count;
  logic        overflow;
  logic        frame_err;

  logic [7:0]  l_data, m_data;
  logic        l_valid, m_valid;
  logic [2:0]  l_count, m_count;
  logic        l_ovf, m_ovf, l_ferr, m_ferr;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  t07_esp_spi_rx dut (
    .clk(clk), .rst(rst), .esp_sclk(esp_sclk), .esp_cs_n(esp_cs_n),
    .esp_mosi(esp_mosi), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .frame_err(frame_err)
  );

  t07_esp_spi_rx #(.WORD_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut8l (
    .clk(clk), .rst(rst), .esp_sclk(esp_sclk), .esp_cs_n(cs8_n),
    .esp_mosi(esp_mosi), .rd_en(rd_en8), .clr_err(clr_err8),
    .rd_data(l_data), .rd_valid(l_valid), .count(l_count),
    .overflow(l_ovf), .frame_err(l_ferr)
  );

  t07_esp_spi_rx #(.WORD_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut8m (
    .clk(clk), .rst(rst), .esp_sclk(esp_sclk), .esp_cs_n(cs8_n),
    .esp_mosi(esp_mosi), .rd_en(rd_en8), .clr_err(clr_err8),
    .rd_data(m_data), .rd_valid(m_valid), .count(m_count),
    .overflow(m_ovf), .frame_err(m_ferr)
  );

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    esp_mosi = b;
    tick(4);
    esp_sclk = 1'b1;
    tick(4);
    esp_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) spi_bit(data[31 - i]);
  endtask

  task automatic frame(input logic [31:0] data);
    tick(4);
    esp_cs_n = 1'b0;
    tick(4);
    send_bits(data, 32);
    tick(4);
    esp_cs_n = 1'b1;
    tick(8);
    if (exp_q.size() < 8) exp_q.push_back(data);
  endtask

  task automatic pop_word(output logic [31:0] d, output logic v);
    v = rd_valid;
    d = rd_data;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rd_valid); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (rd_data !== 32'h0) $display("FAIL reset_data: got %h want 0", rd_data); else n_pass++;
    n_checks++; if ({overflow, frame_err} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {overflow, frame_err}); else n_pass++;
    rst = 1'b0;
    tick(8);
  endtask

  task automatic test_single_word;
    logic [31:0] d, e;
    logic v;
    e = 32'hDEADBEEF;
    tick(4);
    esp_cs_n = 1'b0;
    tick(4);
    send_bits(e, 31);
    esp_mosi = e[0];
    tick(4);
    esp_sclk = 1'b1;
    tick(3);
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL latency_early: got %b want 0", rd_valid); else n_pass++;
    tick(1);
    n_checks++; if (rd_valid !== 1'b1) $display("FAIL latency_edge4: got %b want 1", rd_valid); else n_pass++;
    tick(4);
    esp_sclk = 1'b0;
    tick(4);
    esp_cs_n = 1'b1;
    tick(8);
    exp_q.push_back(e);
    n_checks++; if (count !== 4'd1) $display("FAIL single_count: got %0d want 1", count); else n_pass++;
    pop_word(d, v);
    e = exp_q.pop_front();
    n_checks++; if (v !== 1'b1 || d !== e) $display("FAIL single_data: got %b/%h want 1/%h", v, d, e); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0 || count !== 4'd0) $display("FAIL single_empty: got %b/%0d want 0/0", rd_valid, count); else n_pass++;
    n_checks++; if ({overflow, frame_err} !== 2'b00) $display("FAIL single_flags: got %b want 00", {overflow, frame_err}); else n_pass++;
    // pop on empty FIFO is ignored
    pop_word(d, v);
    n_checks++; if (count !== 4'd0 || rd_data !== 32'h0) $display("FAIL empty_pop: got %0d/%h want 0/0", count, rd_data); else n_pass++;
  endtask

  task automatic test_overflow;
    logic [31:0] d, e;
    logic v;
    for (int i = 1; i <= 9; i++) frame(32'(i));
    n_checks++; if (count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      pop_word(d, v);
      e = exp_q.pop_front();
      n_checks++; if (v !== 1'b1 || d !== e) $display("FAIL ovf_pop%0d: got %b/%h want 1/%h", i, v, d, e); else n_pass++;
    end
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL ovf_drained: got %b want 0", rd_valid); else n_pass++;
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_frame_err;
    logic [31:0] d, e;
    logic v;
    tick(4);
    esp_cs_n = 1'b0;
    tick(4);
    send_bits(32'hFFFFF000, 20);
    tick(4);
    esp_cs_n = 1'b1;
    tick(8);
    n_checks++; if (frame_err !== 1'b1) $display("FAIL ferr_set: got %b want 1", frame_err); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("FAIL ferr_count: got %0d want 0", count); else n_pass++;
    frame(32'hA5A5A5A5);
    pop_word(d, v);
    e = exp_q.pop_front();
    n_checks++; if (v !== 1'b1 || d !== e) $display("FAIL ferr_next: got %b/%h want 1/%h", v, d, e); else n_pass++;
    n_checks++; if (frame_err !== 1'b1) $display("FAIL ferr_sticky: got %b want 1", frame_err); else n_pass++;
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL ferr_clear: got %b want 0", frame_err); else n_pass++;
  endtask

  task automatic test_push_pop_full;
    logic [31:0] d, e, w;
    logic v;
    w = 32'hCAFEF00D;
    for (int i = 0; i < 8; i++) frame(32'h100 + 32'(i));
    n_checks++; if (count !== 4'd8) $display("FAIL full_count: got %0d want 8", count); else n_pass++;
    tick(4);
    esp_cs_n = 1'b0;
    tick(4);
    send_bits(w, 31);
    esp_mosi = w[0];
    tick(4);
    esp_sclk = 1'b1;
    tick(3);
    // the FIFO write lands on the next edge; pop on that same edge
    e = exp_q.pop_front();
    n_checks++; if (rd_data !== e) $display("FAIL full_head: got %h want %h", rd_data, e); else n_pass++;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    exp_q.push_back(w);
    tick(3);
    esp_sclk = 1'b0;
    tick(4);
    esp_cs_n = 1'b1;
    tick(8);
    n_checks++; if (count !== 4'd8) $display("FAIL full_pp_count: got %0d want 8", count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL full_pp_ovf: got %b want 0", overflow); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      pop_word(d, v);
      e = exp_q.pop_front();
      n_checks++; if (v !== 1'b1 || d !== e) $display("FAIL full_pop%0d: got %b/%h want 1/%h", i, v, d, e); else n_pass++;
    end
  endtask

  task automatic test_param_sweep;
    logic [7:0] bits;
    bits = 8'b1000_0000;  // stream order: 1,0,0,0,0,0,0,0
    tick(4);
    cs8_n = 1'b0;
    tick(4);
    for (int i = 7; i >= 0; i--) spi_bit(bits[i]);
    tick(4);
    cs8_n = 1'b1;
    tick(8);
    n_checks++; if (l_valid !== 1'b1 || l_data !== 8'h01) $display("FAIL lsb_first: got %b/%h want 1/01", l_valid, l_data); else n_pass++;
    n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h80) $display("FAIL msb_first: got %b/%h want 1/80", m_valid, m_data); else n_pass++;
    n_checks++; if (l_count !== 3'd1 || m_count !== 3'd1) $display("FAIL w8_count: got %0d/%0d want 1/1", l_count, m_count); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("FAIL w8_isolation: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d, e;
    logic v;
    frame(32'h0BADF00D);
    tick(4);
    esp_cs_n = 1'b0;
    tick(4);
    send_bits(32'hFFFF0000, 16);
    rst = 1'b1;
    exp_q.delete();
    tick(2);
    n_checks++; if (rd_valid !== 1'b0 || count !== 4'd0 || rd_data !== 32'h0)
      $display("FAIL midrst_state: got %b/%0d/%h want 0/0/0", rd_valid, count, rd_data); else n_pass++;
    rst = 1'b0;
    tick(4);
    send_bits(32'hFFFF0000, 8);  // continued clocks with cs low, not armed
    tick(4);
    esp_cs_n = 1'b1;
    tick(8);
    n_checks++; if (count !== 4'd0) $display("FAIL midrst_ignored: got %0d want 0", count); else n_pass++;
    frame(32'h12345678);
    n_checks++; if (count !== 4'd1) $display("FAIL midrst_count: got %0d want 1", count); else n_pass++;
    n_checks++; if ({overflow, frame_err} !== 2'b00) $display("FAIL midrst_flags: got %b want 00", {overflow, frame_err}); else n_pass++;
    pop_word(d, v);
    e = exp_q.pop_front();
    n_checks++; if (v !== 1'b1 || d !== e) $display("FAIL midrst_data: got %b/%h want 1/%h", v, d, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_frame_err();
    test_push_pop_full();
    test_param_sweep();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
